// File: rtl/mult_share_arbiter.sv
// Round-robin front end that lets two requesters share one 8x8 multiplier.
// One operation is in flight at a time; a stuck multiplier is cut off after
// TIMEOUT wait cycles and answered with an error response.
//
// state  | meaning
// IDLE   | no operation; arbitrate and capture the winner's operands
// LAUNCH | single-cycle mult_start strobe with captured operands
// WAIT   | wait for a mult_done rising edge or the timeout
// RESP   | single-cycle rsp_valid pulse to the owner
module mult_share_arbiter #(
    parameter int unsigned TIMEOUT = 32    // legal range 2..63
) (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  dataa0,
    input  logic [7:0]  datab0,
    input  logic [7:0]  dataa1,
    input  logic [7:0]  datab1,
    output logic        grant0,
    output logic        grant1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic [15:0] rsp_product,
    output logic        rsp_err,
    output logic        busy,
    output logic        mult_start,
    output logic [7:0]  mult_dataa,
    output logic [7:0]  mult_datab,
    input  logic        mult_done,
    input  logic [15:0] mult_product
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Counter value on the last allowed WAIT cycle.
    localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    // owner_q is both the current operation's owner and the previous winner
    // used by round-robin; it resets to 1 so requester 0 wins first.
    logic        owner_q, owner_d;
    logic [7:0]  opa_q, opa_d;
    logic [7:0]  opb_q, opb_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        done_prev_q;
    logic [15:0] rsp_product_q, rsp_product_d;
    logic        rsp_err_q, rsp_err_d;
    logic        grant_any;
    logic        win;
    logic        done_rise;

    // A level already high when WAIT starts is not a completion.
    assign done_rise = mult_done & ~done_prev_q;

    // Next-state, arbitration and response-capture logic.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        cnt_d         = cnt_q;
        rsp_product_d = rsp_product_q;
        rsp_err_d     = rsp_err_q;
        grant_any     = 1'b0;
        win           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant_any = 1'b1;
                    win       = (req0 && req1) ? ~owner_q : req1;
                    owner_d   = win;
                    opa_d     = win ? dataa1 : dataa0;
                    opb_d     = win ? datab1 : datab0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = 6'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise) begin
                    rsp_product_d = mult_product;
                    rsp_err_d     = 1'b0;
                    state_d       = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_product_d = 16'd0;
                    rsp_err_d     = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b1;
            opa_q         <= 8'd0;
            opb_q         <= 8'd0;
            cnt_q         <= 6'd0;
            done_prev_q   <= 1'b0;
            rsp_product_q <= 16'd0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            cnt_q         <= cnt_d;
            done_prev_q   <= mult_done;
            rsp_product_q <= rsp_product_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // Grant is a same-cycle pulse; suppressed while reset is asserted.
    assign grant0      = grant_any & ~win & ~reset_a;
    assign grant1      = grant_any &  win & ~reset_a;
    assign rsp_valid0  = (state_q == S_RESP) & ~owner_q;
    assign rsp_valid1  = (state_q == S_RESP) &  owner_q;
    assign rsp_product = rsp_product_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != S_IDLE);
    assign mult_start  = (state_q == S_LAUNCH);
    assign mult_dataa  = opa_q;
    assign mult_datab  = opb_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: table of full transactions plus
// hand-written sequences for stale done, operand stability and reset mid-WAIT.
module tb_mult_share_arbiter;

    localparam int TO = 6;

    logic        clk;
    logic        reset_a;
    logic        req0, req1;
    logic [7:0]  dataa0, datab0, dataa1, datab1;
    logic        grant0, grant1, rsp_valid0, rsp_valid1;
    logic [15:0] rsp_product;
    logic        rsp_err, busy, mult_start;
    logic [7:0]  mult_dataa, mult_datab;
    logic        mult_done;
    logic [15:0] mult_product;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        r0;
        logic        r1;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic [7:0]  a1;
        logic [7:0]  b1;
        int          delay;
        logic        use_done;
        logic        exp_win;
        logic [15:0] exp_prod;
        logic        exp_err;
    } vec_t;

    vec_t vecs [8];

    mult_share_arbiter #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset_a      (reset_a),
        .req0         (req0),
        .req1         (req1),
        .dataa0       (dataa0),
        .datab0       (datab0),
        .dataa1       (dataa1),
        .datab1       (datab1),
        .grant0       (grant0),
        .grant1       (grant1),
        .rsp_valid0   (rsp_valid0),
        .rsp_valid1   (rsp_valid1),
        .rsp_product  (rsp_product),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .mult_start   (mult_start),
        .mult_dataa   (mult_dataa),
        .mult_datab   (mult_datab),
        .mult_done    (mult_done),
        .mult_product (mult_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v);
        logic [7:0] ea, eb;
        int n;
        ea = v.exp_win ? v.a1 : v.a0;
        eb = v.exp_win ? v.b1 : v.b0;
        next_cyc();
        req0 = v.r0; req1 = v.r1;
        dataa0 = v.a0; datab0 = v.b0; dataa1 = v.a1; datab1 = v.b1;
        mult_done = 1'b0;
        #1;
        chk("grant0", 32'(grant0), 32'(!v.exp_win));
        chk("grant1", 32'(grant1), 32'(v.exp_win));
        chk("busy_idle", 32'(busy), 32'd0);
        next_cyc();
        #1;
        chk("mult_start", 32'(mult_start), 32'd1);
        chk("grant_launch", 32'(grant0 | grant1), 32'd0);
        chk("mult_dataa", 32'(mult_dataa), 32'(ea));
        chk("mult_datab", 32'(mult_datab), 32'(eb));
        n = v.use_done ? v.delay : TO;
        for (int k = 1; k <= n; k++) begin
            next_cyc();
            if (v.use_done && k == n) begin
                mult_done    = 1'b1;
                mult_product = 16'(mult_dataa) * 16'(mult_datab);
            end
            #1;
            chk("wait_no_rsp", 32'(rsp_valid0 | rsp_valid1), 32'd0);
            chk("wait_start", 32'(mult_start), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
        end
        next_cyc();
        mult_done = 1'b0; req0 = 1'b0; req1 = 1'b0;
        #1;
        chk("rsp_valid0", 32'(rsp_valid0), 32'(!v.exp_win));
        chk("rsp_valid1", 32'(rsp_valid1), 32'(v.exp_win));
        chk("rsp_product", 32'(rsp_product), 32'(v.exp_prod));
        chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        next_cyc();
        #1;
        chk("busy_after", 32'(busy), 32'd0);
        chk("rsp_gone", 32'(rsp_valid0 | rsp_valid1), 32'd0);
        chk("rsp_hold", 32'(rsp_product), 32'(v.exp_prod));
        chk("err_hold", 32'(rsp_err), 32'(v.exp_err));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_grant", 32'(grant0 | grant1), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid0 | rsp_valid1), 32'd0);
        chk("rst_start", 32'(mult_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(rsp_product), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_dataa", 32'(mult_dataa), 32'd0);
        chk("rst_datab", 32'(mult_datab), 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'd255, 8'd255, 8'd0,  8'd7,  4,  1'b1, 1'b0, 16'd65025, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'd255, 8'd255, 8'd0,  8'd7,  3,  1'b1, 1'b1, 16'd0,     1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'd255, 8'd255, 8'd0,  8'd7,  1,  1'b1, 1'b0, 16'd65025, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'd12,  8'd13,  8'd0,  8'd0,  4,  1'b1, 1'b0, 16'd156,   1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd200, 8'd3, TO, 1'b1, 1'b1, 16'd600,   1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'd9,   8'd9,   8'd0,  8'd0,  0,  1'b0, 1'b0, 16'd0,     1'b1};
        vecs[6] = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd16, 8'd16, 2,  1'b1, 1'b1, 16'd256,   1'b0};
        vecs[7] = '{1'b1, 1'b1, 8'd171, 8'd2,   8'd5,  8'd5,  3,  1'b1, 1'b0, 16'd342,   1'b0};

        reset_a = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        dataa0 = 8'd0; datab0 = 8'd0; dataa1 = 8'd0; datab1 = 8'd0;
        mult_done = 1'b0; mult_product = 16'd0;
        next_cyc();
        next_cyc();
        reset_a = 1'b0;
        #1;
        chk_reset_outputs();

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Stale done: level high before LAUNCH must not complete.
        next_cyc();
        mult_done = 1'b1; mult_product = 16'hdead;
        next_cyc();
        req0 = 1'b1; dataa0 = 8'd3; datab0 = 8'd4;
        #1;
        chk("stale_grant0", 32'(grant0), 32'd1);
        next_cyc();
        #1;
        chk("stale_start", 32'(mult_start), 32'd1);
        for (int k = 0; k < 3; k++) begin
            next_cyc();
            #1;
            chk("stale_no_rsp", 32'(rsp_valid0 | rsp_valid1), 32'd0);
        end
        next_cyc();
        mult_done = 1'b0;
        #1;
        chk("stale_low_no_rsp", 32'(rsp_valid0 | rsp_valid1), 32'd0);
        next_cyc();
        mult_done = 1'b1; mult_product = 16'd12;
        #1;
        chk("stale_rise_no_rsp", 32'(rsp_valid0 | rsp_valid1), 32'd0);
        next_cyc();
        mult_done = 1'b0; req0 = 1'b0;
        #1;
        chk("stale_rsp_valid0", 32'(rsp_valid0), 32'd1);
        chk("stale_product", 32'(rsp_product), 32'd12);
        chk("stale_err", 32'(rsp_err), 32'd0);

        // Operand stability, dropped req, req arriving while busy.
        next_cyc();
        next_cyc();
        req0 = 1'b1; dataa0 = 8'd7; datab0 = 8'd8;
        dataa1 = 8'd10; datab1 = 8'd11;
        #1;
        chk("stab_grant0", 32'(grant0), 32'd1);
        next_cyc();
        next_cyc();
        dataa0 = 8'd99; datab0 = 8'd1; req1 = 1'b1;
        #1;
        chk("stab_dataa", 32'(mult_dataa), 32'd7);
        chk("stab_datab", 32'(mult_datab), 32'd8);
        chk("busy_req_ignored", 32'(grant1), 32'd0);
        next_cyc();
        req0 = 1'b0;
        #1;
        chk("stab_dataa2", 32'(mult_dataa), 32'd7);
        next_cyc();
        mult_done = 1'b1; mult_product = 16'(mult_dataa) * 16'(mult_datab);
        next_cyc();
        mult_done = 1'b0;
        #1;
        chk("drop_rsp_valid0", 32'(rsp_valid0), 32'd1);
        chk("drop_rsp_valid1", 32'(rsp_valid1), 32'd0);
        chk("stab_product", 32'(rsp_product), 32'd56);
        chk("stab_dataa_resp", 32'(mult_dataa), 32'd7);
        next_cyc();
        #1;
        chk("new_req_grant1", 32'(grant1), 32'd1);
        chk("new_req_grant0", 32'(grant0), 32'd0);
        next_cyc();
        req1 = 1'b0;
        #1;
        chk("req1_dataa", 32'(mult_dataa), 32'd10);
        next_cyc();
        mult_done = 1'b1; mult_product = 16'(mult_dataa) * 16'(mult_datab);
        next_cyc();
        mult_done = 1'b0;
        #1;
        chk("req1_rsp_valid1", 32'(rsp_valid1), 32'd1);
        chk("req1_product", 32'(rsp_product), 32'd110);

        // Reset mid-WAIT, owner 0 before reset so previous-winner reset is visible.
        next_cyc();
        next_cyc();
        req0 = 1'b1; dataa0 = 8'd5; datab0 = 8'd6;
        #1;
        chk("rw_grant0", 32'(grant0), 32'd1);
        next_cyc();
        next_cyc();
        req0 = 1'b0;
        next_cyc();
        reset_a = 1'b1;
        next_cyc();
        reset_a = 1'b0;
        #1;
        chk_reset_outputs();
        next_cyc();
        mult_done = 1'b1; mult_product = 16'h1234;
        #1;
        chk("rw_no_rsp1", 32'(rsp_valid0 | rsp_valid1), 32'd0);
        next_cyc();
        mult_done = 1'b0;
        #1;
        chk("rw_no_rsp2", 32'(rsp_valid0 | rsp_valid1), 32'd0);
        chk("rw_idle", 32'(busy), 32'd0);
        next_cyc();
        #1;
        chk("rw_no_rsp3", 32'(rsp_valid0 | rsp_valid1), 32'd0);
        run_txn('{1'b1, 1'b1, 8'd2, 8'd3, 8'd4, 8'd5, 2, 1'b1, 1'b0, 16'd6, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 32; maximum WAIT-state cycles allowed before an operation is aborted; legal range 2..63.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset_a  input  1  synchronous, active-high reset.
REQ-004 Port: req0 / req1  input  1 each  requester 0/1 request level; each requester holds its own request and operands until its rsp_valid.
REQ-005 Port: dataa0, datab0 / dataa1, datab1  input  8 each  operands of requester 0/1.
REQ-006 Port: grant0 / grant1  output  1 each  one-cycle pulse; that requester's operands are captured this cycle.
REQ-007 Port: rsp_valid0 / rsp_valid1  output  1 each  one-cycle response pulse to requester 0/1.
REQ-008 Port: rsp_product  output  16  result; valid only while a rsp_valid is high.
REQ-009 Port: rsp_err  output  1  timeout flag; valid only while a rsp_valid is high.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: mult_start  output  1  start strobe to the shared 8x8 multiplier.
REQ-012 Port: mult_dataa, mult_datab  output  8 each  operands to the multiplier.
REQ-013 Port: mult_done  input  1  multiplier done level.
REQ-014 Port: mult_product  input  16  multiplier result.

Function
REQ-015 States SHALL be IDLE, LAUNCH, WAIT and RESP, encoded in a registered FSM.
REQ-016 In IDLE with any req high, arbitration SHALL take one cycle: assert exactly one grant, capture that requester's operands into the internal operand registers and the winner ID into the owner register, then go to LAUNCH.
REQ-017 Arbitration SHALL be round-robin: with both reqs high, the winner is the requester that was not the previous winner; with one req high, that requester wins.
REQ-018 The previous-winner register SHALL reset to 1, so req0 wins the first contested arbitration.
REQ-019 LAUNCH SHALL last exactly one cycle with mult_start=1, then go to WAIT; mult_start SHALL be 0 in every other state.
REQ-020 mult_dataa/mult_datab SHALL be driven from the captured operand registers.
REQ-021 The captured operands SHALL stay constant from LAUNCH through RESP, regardless of requester inputs.
REQ-022 Completion SHALL be a rising edge of mult_done: mult_done=1 while its registered previous-cycle value is 0.
REQ-023 A mult_done level already high at LAUNCH SHALL NOT complete the operation.
REQ-024 In WAIT, on completion: latch mult_product into rsp_product, clear rsp_err and go to RESP.
REQ-025 A WAIT cycle counter (6-bit) SHALL clear on entry to WAIT and increment every WAIT cycle without completion.
REQ-026 When the WAIT cycle counter reaches TIMEOUT without completion: set rsp_product=0 and rsp_err=1, then go to RESP.
REQ-027 If completion and the TIMEOUT condition occur in the same cycle, completion SHALL win.
REQ-028 RESP SHALL last one cycle: assert rsp_valid of the owner only, then return to IDLE.
REQ-029 rsp_product and rsp_err SHALL hold their values until the next response.
REQ-030 Latency: req sampled high in IDLE at cycle N gives grant at N, mult_start at N+1 and WAIT from N+2. A done edge at cycle M gives rsp_valid at M+1 and IDLE at M+2.
REQ-031 A requester dropping req mid-operation SHALL NOT abort the operation; the response is still pulsed.
REQ-032 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-033 Requests arriving while busy=1 SHALL be ignored until IDLE; no queuing.
REQ-034 At most one grant, one rsp_valid and one outstanding operation SHALL exist at any time.

Reset
REQ-035 reset_a=1 at a clock edge SHALL force state IDLE, regardless of current state, including mid-WAIT.
REQ-036 The same reset SHALL force the following values:
- grant0/1=0, rsp_valid0/1=0, mult_start=0, busy=0;
- rsp_product=0, rsp_err=0;
- captured operands, mult_dataa and mult_datab=0;
- WAIT counter=0, previous-done register=0, previous winner=1.
REQ-037 An operation interrupted by reset SHALL produce no response; a later mult_done edge SHALL be ignored while in IDLE.

Verification
REQ-038 Single request: req0=1, dataa0=12, datab0=13; the model asserts done 4 cycles after start with product 156 -> grant0 at N, mult_start at N+1, rsp_valid0 one cycle after the done edge, rsp_product=16'd156, rsp_err=0.
REQ-039 Contention after reset: req0=req1=1 held -> grant0 first, then grant1 for the next operation, alternating thereafter; results 255x255=16'd65025 and 0x7=16'd0 routed to the correct rsp_valid.
REQ-040 Timeout: mult_done held 0 -> rsp_valid0 with rsp_err=1 and rsp_product=0 exactly TIMEOUT WAIT cycles after entering WAIT; busy=0 the following cycle.
REQ-041 Stale done: mult_done high before LAUNCH and held -> no completion; done falls then rises -> response on the rise.
REQ-042 Reset mid-WAIT: reset_a=1 for one cycle -> next cycle all outputs at reset values; a subsequent done edge produces no rsp_valid.
REQ-043 Operand stability: change dataa0/datab0 during WAIT -> mult_dataa/mult_datab unchanged until the response.
